punc_mem_responder: RTL and testbench

//  - Responder side of the PUnC memory interface: serves single-outstanding read/write

---
 rtl/punc_mem_responder_if.sv | 25 ++
 rtl/punc_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_punc_mem_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_mem_responder_if.sv
// Request/response handshake bundle between the PUnC datapath (master) and the
// memory responder (slave). Addresses are always 16 bits wide; data is DATA_W.
interface punc_mem_responder_if #(
    parameter int DATA_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [15:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_is_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );
endinterface

// File: rtl/punc_mem_responder.sv
// PUnC memory responder: single-outstanding word store with programmable response latency.
// Optional console MMIO (write 0xFE06, status read 0xFE04) enabled by PUNC_MEM_MMIO_EN.
module punc_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    punc_mem_responder_if.slave   bus,
    input  logic [15:0]           dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
`ifdef PUNC_MEM_MMIO_EN
    ,
    output logic [DATA_W-1:0]     con_data,
    output logic                  con_valid
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    logic [DATA_W-1:0] store_q [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_is_wr_q, rsp_is_wr_d;

    logic              accept;
    logic              store_we;
    logic [ADDR_W-1:0] req_word;
    logic              unused_addr_bits;

    assign req_word = bus.req_addr[ADDR_W-1:0];
    assign accept   = bus.req_valid & req_ready_q;
    assign unused_addr_bits = &{1'b0, bus.req_addr[15:ADDR_W], dbg_addr[15:ADDR_W]};

`ifdef PUNC_MEM_MMIO_EN
    logic [DATA_W-1:0] con_data_q, con_data_d;
    logic              con_valid_q, con_valid_d;
    logic              is_con_wr, is_con_rd;

    // Console decode compares all 16 address bits, so it never aliases the store.
    assign is_con_wr = bus.req_we & (bus.req_addr == 16'hFE06);
    assign is_con_rd = ~bus.req_we & (bus.req_addr == 16'hFE04);
    assign store_we  = accept & bus.req_we & ~is_con_wr;
    assign con_data  = con_data_q;
    assign con_valid = con_valid_q;
`else
    assign store_we  = accept & bus.req_we;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_is_wr_d = rsp_is_wr_q;
`ifdef PUNC_MEM_MMIO_EN
        con_data_d  = con_data_q;
        con_valid_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    rsp_is_wr_d = bus.req_we;
                    rsp_rdata_d = bus.req_we ? '0 : store_q[req_word];
`ifdef PUNC_MEM_MMIO_EN
                    if (is_con_rd) rsp_rdata_d = DATA_W'(16'h8000);
                    if (is_con_wr) begin
                        con_data_d  = bus.req_wdata;
                        con_valid_d = 1'b1;
                    end
`endif
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d     = ST_RESP;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Completing the response only reopens the request side next cycle.
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 4'd0;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_is_wr_q <= 1'b0;
`ifdef PUNC_MEM_MMIO_EN
            con_data_q  <= '0;
            con_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_is_wr_q <= rsp_is_wr_d;
`ifdef PUNC_MEM_MMIO_EN
            con_data_q  <= con_data_d;
            con_valid_q <= con_valid_d;
`endif
        end
    end

    // NOTE: the store has no reset; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst && store_we) begin
            store_q[req_word] <= bus.req_wdata;
        end
    end

    assign dbg_data      = store_q[dbg_addr[ADDR_W-1:0]];
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_is_wr = rsp_is_wr_q;

endmodule

// File: tb/tb_punc_mem_responder.sv
// Directed bench for punc_mem_responder: a LATENCY=2 instance carries most tests,
// a LATENCY=1 instance checks single-cycle response timing.
module tb_punc_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [15:0] req_addr, req_wdata, dbg_addr;

    logic        w_req_ready, w_rsp_valid, w_rsp_is_wr;
    logic [15:0] w_rsp_rdata, w_dbg_data;
    logic [15:0] dbg_data0, dbg_data1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    punc_mem_responder_if #(.DATA_W(16)) bus ();
    punc_mem_responder_if #(.DATA_W(16)) bus1 ();

    assign bus.req_valid  = req_valid & ~sel;
    assign bus.req_we     = req_we;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.rsp_ready  = rsp_ready & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus1.req_we    = req_we;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus1.rsp_ready = rsp_ready & sel;

    assign w_req_ready = sel ? bus1.req_ready : bus.req_ready;
    assign w_rsp_valid = sel ? bus1.rsp_valid : bus.rsp_valid;
    assign w_rsp_rdata = sel ? bus1.rsp_rdata : bus.rsp_rdata;
    assign w_rsp_is_wr = sel ? bus1.rsp_is_wr : bus.rsp_is_wr;
    assign w_dbg_data  = sel ? dbg_data1 : dbg_data0;

`ifdef PUNC_MEM_MMIO_EN
    logic [15:0] con_data0, con_data1;
    logic        con_valid0, con_valid1;
    int          con_pulses = 0;
    logic [15:0] con_last;

    always @(negedge clk) begin
        if (con_valid0) begin
            con_pulses++;
            con_last = con_data0;
        end
    end
`endif

    punc_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data0)
`ifdef PUNC_MEM_MMIO_EN
        ,
        .con_data (con_data0),
        .con_valid(con_valid0)
`endif
    );

    punc_mem_responder #(.ADDR_W(10), .DATA_W(16), .LATENCY(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus1),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data1)
`ifdef PUNC_MEM_MMIO_EN
        ,
        .con_data (con_data1),
        .con_valid(con_valid1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: accept, measure latency, optionally stall the response.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int stall, input int exp_lat, input logic chk_dbg,
                       input logic [15:0] exp_rd, input string name);
        int n;
        n = 0;
        while (!w_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " req_ready"}, 32'(w_req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        dbg_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hDEAD;
        if (chk_dbg && we) check({name, " dbg after accept"}, 32'(w_dbg_data), 32'(wdata));
        n = 1;
        while (!w_rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " rdata"}, 32'(w_rsp_rdata), 32'(exp_rd));
        check({name, " is_wr"}, 32'(w_rsp_is_wr), 32'(we));
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 16'h0300;
            req_wdata = 16'h5555;
            @(posedge clk); #1;
            check({name, " stall rsp_valid"}, 32'(w_rsp_valid), 32'd1);
            check({name, " stall rdata"}, 32'(w_rsp_rdata), 32'(exp_rd));
            check({name, " stall req_ready"}, 32'(w_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, " rsp_valid drop"}, 32'(w_rsp_valid), 32'd0);
        check({name, " req_ready back"}, 32'(w_req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int seen;
        vecs[0] = '{1'b1, 16'h0005, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0405, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 16'h03FF, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b0, 16'h07FF, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b1, 16'h0000, 16'h0001, 16'h0000};
        vecs[7] = '{1'b0, 16'hFC00, 16'h0000, 16'h0001};

        sel       = 1'b0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        dbg_addr  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(w_req_ready), 32'd1);
        check("reset rsp_valid", 32'(w_rsp_valid), 32'd0);
        check("reset rsp_rdata", 32'(w_rsp_rdata), 32'd0);
        check("reset rsp_is_wr", 32'(w_rsp_is_wr), 32'd0);
`ifdef PUNC_MEM_MMIO_EN
        check("reset con_valid", 32'(con_valid0), 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 2, 1'b1, vecs[i].exp_rd,
                $sformatf("vec%0d", i));
        end

        // Response stalled three cycles while a stray request is offered.
        txn(1'b0, 16'h0005, 16'h0000, 3, 2, 1'b0, 16'hBEEF, "stall_rd");
        txn(1'b0, 16'h0300, 16'h0000, 0, 2, 1'b0, 16'h0000, "stray_ignored");

        // Reset while the write is waiting: response dropped, write kept.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'h00AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b1;
        check("midreset req_ready", 32'(w_req_ready), 32'd1);
        check("midreset rsp_valid", 32'(w_rsp_valid), 32'd0);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (w_rsp_valid) seen = 1;
        end
        check("midreset no rsp", 32'(seen), 32'd0);
        txn(1'b0, 16'h0010, 16'h0000, 0, 2, 1'b0, 16'h00AA, "midreset_rd");

`ifdef PUNC_MEM_MMIO_EN
        txn(1'b1, 16'hFE06, 16'h0041, 0, 2, 1'b0, 16'h0000, "con_wr");
        check("con pulses", 32'(con_pulses), 32'd1);
        check("con data", 32'(con_last), 32'h0041);
        txn(1'b0, 16'hFE04, 16'h0000, 0, 2, 1'b0, 16'h8000, "con_status");
`else
        txn(1'b1, 16'hFE06, 16'h0041, 0, 2, 1'b1, 16'h0000, "fe06_wr");
        txn(1'b0, 16'hFE06, 16'h0000, 0, 2, 1'b0, 16'h0041, "fe06_rd");
        dbg_addr = 16'h0206;
        #1;
        check("dbg word 0x206", 32'(w_dbg_data), 32'h0041);
`endif

        dbg_addr = 16'h03FF;
        #1;
        check("dbg 0x3FF", 32'(w_dbg_data), 32'hA5A5);
        dbg_addr = 16'h0005;
        #1;
        check("dbg 0x005", 32'(w_dbg_data), 32'hBEEF);

        sel = 1'b1;
        #1;
        txn(1'b1, 16'h0405, 16'hBEEF, 0, 1, 1'b1, 16'h0000, "lat1_wr");
        txn(1'b0, 16'h0005, 16'h0000, 2, 1, 1'b0, 16'hBEEF, "lat1_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
